// File: rtl/boot_loader_pkg.sv
// Shared definitions for the boot loader: FSM states, stream target codes
// and default memory capacities.
package boot_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_COUNT = 3'd1,
        ST_DATA  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERROR = 3'd5
    } state_t;

    localparam logic [7:0] TGT_IMEM = 8'h00;
    localparam logic [7:0] TGT_DMEM = 8'h01;
    localparam logic [7:0] TGT_END  = 8'hFF;

    localparam int I_WORDS_DEF = 16;
    localparam int D_WORDS_DEF = 20;

    // True for a byte that opens a segment (instruction or data memory).
    function automatic logic is_target(input logic [7:0] b);
        return (b == TGT_IMEM) || (b == TGT_DMEM);
    endfunction

endpackage

// File: rtl/boot_loader_if.sv
// Byte-stream input and memory-write bus of the boot loader.
//
// Handshake: a byte moves from upstream to the loader on a rising clk edge
// where in_valid and in_ready are both 1. in_ready depends only on loader
// state, never on in_valid, so upstream may hold in_valid/in_byte for any
// number of cycles. mem_write is a one-cycle strobe with no back-pressure.
interface boot_loader_if;

    logic        in_valid;
    logic [7:0]  in_byte;
    logic        in_ready;
    logic        mem_write;
    logic        mem_select;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;

    // Loader side.
    modport master (
        input  in_valid,
        input  in_byte,
        output in_ready,
        output mem_write,
        output mem_select,
        output mem_address,
        output mem_write_data
    );

    // Stream source and memory side.
    modport slave (
        output in_valid,
        output in_byte,
        input  in_ready,
        input  mem_write,
        input  mem_select,
        input  mem_address,
        input  mem_write_data
    );

endinterface

// File: rtl/boot_loader_byte_packer.sv
// Assembles four stream bytes, MSB first, into one 32-bit word.
module byte_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        shift,
    input  logic        clear,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic [1:0]  count,
    output logic        word_full
);

    // Shift accepted bytes in; a full word is frozen until cleared.
    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            word      <= 32'd0;
            count     <= 2'd0;
            word_full <= 1'b0;
        end else if (shift && !word_full) begin
            word  <= {word[23:0], byte_in};
            count <= count + 2'd1;
            if (count == 2'd3) begin
                word_full <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/boot_loader.sv
// Boot loader: parses a segmented byte stream and writes the words into
// instruction or data memory, then releases the core from reset.
module boot_loader
    import boot_loader_pkg::*;
#(
    parameter int I_WORDS = I_WORDS_DEF,
    parameter int D_WORDS = D_WORDS_DEF
) (
    input  logic          clk,
    input  logic          rst,
    boot_loader_if.master bus,
    output logic          core_rst,
    output logic          done,
    output logic          error,
    output state_t        state
);

    state_t      next_state;
    logic        ready_q;
    logic        ready_next;
    logic        sel_q;
    logic [31:0] addr_q;
    logic [31:0] last_word_q;
    logic [7:0]  count_q;
    logic [31:0] cap_words;
    logic        n_ok;
    logic        accept;

    logic [31:0] pk_word;
    logic [1:0]  pk_count;
    logic        pk_full;

    assign accept    = bus.in_valid && ready_q;
    assign cap_words = sel_q ? 32'(D_WORDS) : 32'(I_WORDS);
    assign n_ok      = (bus.in_byte != 8'd0) && ({24'd0, bus.in_byte} <= cap_words);

    byte_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .shift     ((state == ST_DATA) && accept),
        .clear     (state == ST_WRITE),
        .byte_in   (bus.in_byte),
        .word      (pk_word),
        .count     (pk_count),
        .word_full (pk_full)
    );

    // Next-state decode; only accepted bytes move the parser, WRITE is unconditional.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (is_target(bus.in_byte)) begin
                        next_state = ST_COUNT;
                    end else if (bus.in_byte == TGT_END) begin
                        next_state = ST_DONE;
                    end else begin
                        next_state = ST_ERROR;
                    end
                end
            end
            ST_COUNT: begin
                if (accept) begin
                    next_state = n_ok ? ST_DATA : ST_ERROR;
                end
            end
            ST_DATA: begin
                if (accept && (pk_count == 2'd3)) begin
                    next_state = ST_WRITE;
                end
            end
            ST_WRITE: begin
                next_state = (count_q == 8'd1) ? ST_IDLE : ST_DATA;
            end
            ST_DONE:  next_state = ST_DONE;
            ST_ERROR: next_state = ST_ERROR;
            default:  next_state = ST_ERROR;
        endcase
    end

    // in_ready is registered from the next state so it stays low through the
    // first edge after reset release.
    assign ready_next = (next_state == ST_IDLE) || (next_state == ST_COUNT) ||
                        (next_state == ST_DATA);

    // State register and handshake flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= ST_IDLE;
            ready_q <= 1'b0;
        end else begin
            state   <= next_state;
            ready_q <= ready_next;
        end
    end

    // Segment target, write address, remaining word count and last written word.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sel_q       <= 1'b0;
            addr_q      <= 32'd0;
            count_q     <= 8'd0;
            last_word_q <= 32'd0;
        end else begin
            if ((state == ST_IDLE) && accept && is_target(bus.in_byte)) begin
                sel_q <= bus.in_byte[0];
            end
            if ((state == ST_COUNT) && accept && n_ok) begin
                addr_q  <= 32'd0;
                count_q <= bus.in_byte;
            end
            if (state == ST_WRITE) begin
                addr_q      <= addr_q + 32'd4;
                count_q     <= count_q - 8'd1;
                last_word_q <= pk_word;
            end
        end
    end

    assign bus.in_ready       = ready_q;
    assign bus.mem_write      = (state == ST_WRITE) && pk_full;
    assign bus.mem_select     = sel_q;
    assign bus.mem_address    = addr_q;
    assign bus.mem_write_data = (state == ST_WRITE) ? pk_word : last_word_q;
    assign core_rst           = (state == ST_DONE);
    assign done               = (state == ST_DONE);
    assign error              = (state == ST_ERROR);

endmodule

// File: tb/tb_boot_loader.sv
// Self-checking bench for boot_loader: directed streams for the documented
// cases plus random segmented streams scored against a stream-parsing model.
module tb_boot_loader;
    import boot_loader_pkg::*;

    localparam int W = 65;  // {select, address, data}

    logic   clk = 1'b0;
    logic   rst = 1'b0;
    logic   core_rst;
    logic   done;
    logic   error;
    state_t state;

    boot_loader_if bus ();

    boot_loader #(.I_WORDS(16), .D_WORDS(20)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .core_rst (core_rst),
        .done     (done),
        .error    (error),
        .state    (state)
    );

    // Clock.
    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    logic [W-1:0] exp_q[$];
    logic [7:0]  stream[$];
    bit          wend[$];
    int          exp_status;   // 0 open, 1 done, 2 error
    int          exp_len;
    int          exp_writes;
    logic        exp_sel;
    logic [31:0] exp_addr;
    logic [31:0] exp_word;
    int          n_writes = 0;
    bit          mon_en = 1'b0;
    logic        prev_write = 1'b0;
    logic [31:0] last_word = 32'd0;

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Write monitor / scoreboard.
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.mem_write === 1'b1) begin
                n_writes++;
                check("in_ready_in_write", bus.in_ready, 0);
                check("write_single_cycle", prev_write, 0);
                check("write_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    check("write_record", {bus.mem_select, bus.mem_address, bus.mem_write_data},
                          exp_q.pop_front());
                end
                last_word = bus.mem_write_data;
            end else begin
                check("wdata_hold", bus.mem_write_data, last_word);
            end
            prev_write = bus.mem_write;
        end
    end

    // Reference model: parse the stream by its segment rules.
    task automatic build_model();
        int i;
        int n;
        int cap;
        logic [7:0]  t;
        logic [31:0] w;
        i = 0;
        exp_status = 0;
        exp_len = stream.size();
        exp_writes = 0;
        exp_sel = 1'b0;
        exp_addr = 32'd0;
        exp_word = 32'd0;
        wend.delete();
        foreach (stream[k]) wend.push_back(1'b0);
        while (i < stream.size() && exp_status == 0) begin
            t = stream[i];
            if (t == 8'hFF) begin
                exp_status = 1;
                exp_len = i + 1;
            end else if (t != 8'h00 && t != 8'h01) begin
                exp_status = 2;
                exp_len = i + 1;
            end else begin
                exp_sel = t[0];
                n = int'(stream[i+1]);
                cap = (t == 8'h00) ? 16 : 20;
                if (n == 0 || n > cap) begin
                    exp_status = 2;
                    exp_len = i + 2;
                end else begin
                    i += 2;
                    for (int k = 0; k < n; k++) begin
                        w = {stream[i], stream[i+1], stream[i+2], stream[i+3]};
                        exp_q.push_back({t[0], 32'(k * 4), w});
                        wend[i+3] = 1'b1;
                        exp_word = w;
                        exp_addr = 32'((k + 1) * 4);
                        exp_writes++;
                        i += 4;
                    end
                end
            end
        end
    endtask

    // Driver: offer one byte after some idle cycles, wait (bounded) for acceptance.
    task automatic send_byte(input logic [7:0] b, input int gaps, input bit is_end);
        int n;
        repeat (gaps) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            bus.in_byte  = 8'($urandom);
        end
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_byte  = b;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (bus.in_ready !== 1'b1) begin
            check("ready_timeout", bus.in_ready, 1);
            return;
        end
        @(posedge clk);
        if (is_end) begin
            @(negedge clk);
            check("write_latency", bus.mem_write, 1);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        mon_en = 1'b0;
        rst = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_mem_write", bus.mem_write, 0);
        check("rst_mem_select", bus.mem_select, 0);
        check("rst_mem_address", bus.mem_address, 0);
        check("rst_mem_wdata", bus.mem_write_data, 0);
        check("rst_core_rst", core_rst, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_state", state, ST_IDLE);
        exp_q.delete();
        last_word = 32'd0;
        prev_write = 1'b0;
        n_writes = 0;
        mon_en = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        check("ready_after_release", bus.in_ready, 1);
    endtask

    task automatic run_stream(input int gmin, input int gmax);
        build_model();
        n_writes = 0;
        for (int k = 0; k < exp_len; k++) begin
            send_byte(stream[k], $urandom_range(gmin, gmax), wend[k]);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("done", done, exp_status == 1);
        check("core_rst", core_rst, exp_status == 1);
        check("error", error, exp_status == 2);
        check("in_ready_final", bus.in_ready, exp_status == 0);
        check("state_final", state, (exp_status == 1) ? ST_DONE : ST_ERROR);
        check("write_count", n_writes, exp_writes);
        check("queue_drained", exp_q.size(), 0);
        if (exp_status == 1) begin
            check("final_select", bus.mem_select, exp_sel);
            check("final_address", bus.mem_address, exp_addr);
            check("final_wdata", bus.mem_write_data, exp_word);
        end
    endtask

    task automatic gen_random();
        int nseg;
        int t;
        int cap;
        int n;
        int r;
        stream.delete();
        nseg = $urandom_range(1, 3);
        for (int s = 0; s < nseg; s++) begin
            t = $urandom_range(0, 1);
            cap = (t == 1) ? 20 : 16;
            n = ($urandom_range(0, 3) == 0) ? cap : $urandom_range(1, 6);
            stream.push_back(8'(t));
            stream.push_back(8'(n));
            for (int k = 0; k < 4 * n; k++) stream.push_back(8'($urandom));
        end
        r = $urandom_range(0, 5);
        if (r == 0) begin
            stream.push_back(8'($urandom_range(2, 254)));
        end else if (r == 1) begin
            stream.push_back(8'h00);
            stream.push_back(8'h00);
        end else if (r == 2) begin
            stream.push_back(8'h01);
            stream.push_back(8'd21);
        end else begin
            stream.push_back(8'hFF);
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_byte  = 8'h00;

        // Reset values and release.
        do_reset();

        // Two imem words back to back.
        stream = '{8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hFF};
        run_stream(0, 0);

        // Reset from DONE, then one dmem word with a stall before every byte.
        do_reset();
        stream = '{8'h01, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hFF};
        run_stream(1, 1);

        // Count over imem capacity; input ignored afterwards.
        do_reset();
        stream = '{8'h00, 8'h11};
        run_stream(0, 0);
        repeat (5) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_byte  = 8'($urandom);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("error_held", error, 1);
        check("error_ready_low", bus.in_ready, 0);
        check("error_core_rst", core_rst, 0);
        check("error_no_write", n_writes, 0);

        // Bad target, zero count.
        do_reset();
        stream = '{8'h05};
        run_stream(0, 1);
        do_reset();
        stream = '{8'h01, 8'h00};
        run_stream(0, 1);

        // Capacity boundaries.
        do_reset();
        stream = '{8'h00, 8'h10};
        for (int k = 0; k < 64; k++) stream.push_back(8'($urandom));
        stream.push_back(8'hFF);
        run_stream(0, 1);
        do_reset();
        stream = '{8'h01, 8'h14};
        for (int k = 0; k < 80; k++) stream.push_back(8'($urandom));
        stream.push_back(8'hFF);
        run_stream(0, 1);
        do_reset();
        stream = '{8'h01, 8'h15};
        run_stream(0, 0);

        // Repeated segment to the same target restarts at address 0.
        do_reset();
        stream = '{8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04,
                   8'h00, 8'h01, 8'hF1, 8'hF2, 8'hF3, 8'hF4, 8'hFF};
        run_stream(0, 2);

        // Reset mid-word discards the partial word.
        do_reset();
        send_byte(8'h01, 0, 1'b0);
        send_byte(8'h01, 0, 1'b0);
        send_byte(8'hAA, 0, 1'b0);
        send_byte(8'hBB, 0, 1'b0);
        do_reset();
        check("partial_no_write", n_writes, 0);
        stream = '{8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h08, 8'hFF};
        run_stream(0, 0);

        // Random segmented streams with random stalls.
        for (int it = 0; it < 12; it++) begin
            do_reset();
            gen_random();
            run_stream(0, 2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Overall time limit.
    initial begin
        #2000000;
        failures++;
        $display("FAIL global_timeout: observed=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
